// File: rtl/piece_rotate_ctrl.sv
// Rotation controller: captures a spinner candidate, checks its four cells
// serially against bounds and the locked-cell board, and commits only if all pass.
module piece_rotate_ctrl #(
  parameter int XSIZE = 3,
  parameter int YSIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [3:0][XSIZE:0]   load_x,
  input  logic [3:0][YSIZE:0]   load_y,
  input  logic                  rot_req,
  input  logic [3:0][XSIZE:0]   cand_x,
  input  logic [3:0][YSIZE:0]   cand_y,
  input  logic [1:0]            cand_spin,
  output logic [XSIZE-1:0]      rd_x,
  output logic [YSIZE-1:0]      rd_y,
  input  logic                  rd_occ,
  output logic [3:0][XSIZE:0]   cur_x,
  output logic [3:0][YSIZE:0]   cur_y,
  output logic [1:0]            spin_state,
  output logic                  busy,
  output logic                  done,
  output logic                  ok
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0][XSIZE:0] shadow_x;
  logic [3:0][YSIZE:0] shadow_y;
  logic [1:0]          shadow_spin;
  logic [1:0]          idx;
  logic                cell_fail;
  logic                accept;

  assign accept    = (state == IDLE) && rot_req && !load;
  // Out-of-range flags fail the cell whatever the board reports for the wrapped index.
  assign cell_fail = shadow_x[idx][XSIZE] | shadow_y[idx][YSIZE] | rd_occ;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rot_req) state_nxt = CHECK;
        CHECK:   if (cell_fail || idx == 2'd3) state_nxt = RESP;
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == CHECK) || (state == RESP);
    done = (state == RESP);
    rd_x = '0;
    rd_y = '0;
    if (state == CHECK) begin
      rd_x = shadow_x[idx][XSIZE-1:0];
      rd_y = shadow_y[idx][YSIZE-1:0];
    end
  end

  // NOTE: shadow registers carry no reset; they are always written on accept
  // before CHECK reads them, so their power-up value is never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_x    <= cand_x;
      shadow_y    <= cand_y;
      shadow_spin <= cand_spin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_x      <= '0;
      cur_y      <= '0;
      spin_state <= '0;
      idx        <= '0;
      ok         <= 1'b0;
    end else if (load) begin
      cur_x      <= load_x;
      cur_y      <= load_y;
      spin_state <= '0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: if (rot_req) idx <= '0;
        CHECK: begin
          if (cell_fail) begin
            ok <= 1'b0;
          end else if (idx == 2'd3) begin
            ok         <= 1'b1;
            cur_x      <= shadow_x;
            cur_y      <= shadow_y;
            spin_state <= shadow_spin;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_rotate_ctrl.sv
// Directed bench for piece_rotate_ctrl: table of rotation attempts against a
// modelled board plus hand-written abort / held-request sequences.
module tb_piece_rotate_ctrl;
  localparam int XSIZE = 3;
  localparam int YSIZE = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                load;
  logic [3:0][XSIZE:0] load_x;
  logic [3:0][YSIZE:0] load_y;
  logic                rot_req;
  logic [3:0][XSIZE:0] cand_x;
  logic [3:0][YSIZE:0] cand_y;
  logic [1:0]          cand_spin;
  logic [XSIZE-1:0]    rd_x;
  logic [YSIZE-1:0]    rd_y;
  logic                rd_occ;
  logic [3:0][XSIZE:0] cur_x;
  logic [3:0][YSIZE:0] cur_y;
  logic [1:0]          spin_state;
  logic                busy, done, ok;

  logic [63:0] board;   // bit y*8+x set = locked cell
  assign rd_occ = board[{rd_y, rd_x}];

  piece_rotate_ctrl #(.XSIZE(XSIZE), .YSIZE(YSIZE)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_x(load_x), .load_y(load_y),
    .rot_req(rot_req), .cand_x(cand_x), .cand_y(cand_y), .cand_spin(cand_spin),
    .rd_x(rd_x), .rd_y(rd_y), .rd_occ(rd_occ), .cur_x(cur_x), .cur_y(cur_y),
    .spin_state(spin_state), .busy(busy), .done(done), .ok(ok)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic [15:0] cx;
    logic [15:0] cy;
    logic [1:0]  spin;
    logic [63:0] brd;
    logic        exp_ok;
    int          exp_k;
  } vec_t;

  vec_t vecs[6];

  localparam logic [15:0] SPAWN_X = {4'd3, 4'd3, 4'd3, 4'd3};
  localparam logic [15:0] SPAWN_Y = {4'd4, 4'd3, 4'd2, 4'd1};

  task automatic set_vec(input int i, input logic [15:0] cx, input logic [15:0] cy,
                         input logic [1:0] sp, input logic [63:0] brd,
                         input logic eok, input int k);
    vecs[i].cx = cx; vecs[i].cy = cy; vecs[i].spin = sp;
    vecs[i].brd = brd; vecs[i].exp_ok = eok; vecs[i].exp_k = k;
  endtask

  task automatic load_piece(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    load = 1'b1; load_x = x; load_y = y;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  task automatic attempt(input int vi);
    vec_t v;
    logic [3:0][XSIZE:0] ex;
    logic [3:0][YSIZE:0] ey;
    int cyc;
    v = vecs[vi];
    ex = v.cx;
    ey = v.cy;
    board = v.brd;
    @(negedge clk);
    cand_x = v.cx; cand_y = v.cy; cand_spin = v.spin; rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    cand_x = '1; cand_y = '1; cand_spin = 2'd0;   // shadow must isolate these
    cyc = 1;
    while (!done && cyc <= 6) begin
      if (cyc <= 4) begin
        check($sformatf("v%0d rd_x c%0d", vi, cyc), 64'(rd_x), 64'(ex[cyc-1][XSIZE-1:0]));
        check($sformatf("v%0d rd_y c%0d", vi, cyc), 64'(rd_y), 64'(ey[cyc-1][YSIZE-1:0]));
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d done cycle", vi), 64'(cyc), 64'(v.exp_k + 1));
    check($sformatf("v%0d ok", vi), 64'(ok), 64'(v.exp_ok));
    check($sformatf("v%0d busy in resp", vi), 64'(busy), 64'd1);
    check($sformatf("v%0d rd_x in resp", vi), 64'(rd_x), 64'd0);
    check($sformatf("v%0d cur_x", vi), 64'(cur_x), 64'(v.exp_ok ? v.cx : SPAWN_X));
    check($sformatf("v%0d cur_y", vi), 64'(cur_y), 64'(v.exp_ok ? v.cy : SPAWN_Y));
    check($sformatf("v%0d spin", vi), 64'(spin_state), 64'(v.exp_ok ? v.spin : 2'd0));
    @(negedge clk);
    check($sformatf("v%0d done after", vi), 64'(done), 64'd0);
    check($sformatf("v%0d busy after", vi), 64'(busy), 64'd0);
  endtask

  initial begin : main
    int n;
    int busy_at6, busy_at7, done_at;
    rst_n = 1'b0; load = 1'b0; rot_req = 1'b0;
    load_x = '0; load_y = '0; cand_x = '0; cand_y = '0; cand_spin = '0;
    board = '0;

    set_vec(0, {4'd5, 4'd4, 4'd3, 4'd2}, {4'd2, 4'd2, 4'd2, 4'd2}, 2'd1, 64'd0, 1'b1, 4);
    set_vec(1, {4'd5, 4'd4, 4'd3, 4'hF}, {4'd2, 4'd2, 4'd2, 4'd2}, 2'd2, 64'd0, 1'b0, 1);
    set_vec(2, {4'd5, 4'd4, 4'd3, 4'd2}, {4'd2, 4'd2, 4'd2, 4'd2}, 2'd3, 64'd1 << 21, 1'b0, 4);
    set_vec(3, {4'd1, 4'd2, 4'd3, 4'd4}, {4'd1, 4'd8, 4'd1, 4'd1}, 2'd1, 64'd0, 1'b0, 3);
    set_vec(4, {4'd6, 4'd6, 4'd6, 4'd6}, {4'd3, 4'd2, 4'd1, 4'd0}, 2'd1, 64'd1 << 14, 1'b0, 2);
    set_vec(5, {4'd7, 4'd7, 4'd0, 4'd0}, {4'd7, 4'd0, 4'd7, 4'd0}, 2'd2,
            (64'd1 << 62) | (64'd1 << 1) | (64'd1 << 55), 1'b1, 4);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset cur_x", 64'(cur_x), 64'd0);
    check("reset cur_y", 64'(cur_y), 64'd0);
    check("reset spin", 64'(spin_state), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset ok", 64'(ok), 64'd0);
    check("reset rd", 64'({rd_y, rd_x}), 64'd0);
    rst_n = 1'b1;

    // Spawn
    load_piece(SPAWN_X, SPAWN_Y);
    check("spawn cur_x", 64'(cur_x), 64'(SPAWN_X));
    check("spawn cur_y", 64'(cur_y), 64'(SPAWN_Y));
    check("spawn spin", 64'(spin_state), 64'd0);
    check("spawn busy", 64'(busy), 64'd0);
    check("spawn done", 64'(done), 64'd0);

    for (int i = 0; i < 6; i++) begin
      load_piece(SPAWN_X, SPAWN_Y);
      attempt(i);
    end

    // rot_req held high: one done per attempt, gap of one IDLE cycle
    board = '0;
    load_piece(SPAWN_X, SPAWN_Y);
    @(negedge clk);
    cand_x = vecs[0].cx; cand_y = vecs[0].cy; cand_spin = 2'd1; rot_req = 1'b1;
    n = 0; busy_at6 = -1; busy_at7 = -1; done_at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin n++; if (done_at == 0) done_at = i; end
      if (i == 6) busy_at6 = int'(busy);
      if (i == 7) busy_at7 = int'(busy);
    end
    rot_req = 1'b0;
    check("held done count", 64'(n), 64'd1);
    check("held done cycle", 64'(done_at), 64'd5);
    check("held idle gap", 64'(busy_at6), 64'd0);
    check("held second start", 64'(busy_at7), 64'd1);
    count_done(3, n);
    check("held second done", 64'(n), 64'd1);
    check("held spin", 64'(spin_state), 64'd1);

    // load together with rot_req in IDLE: load wins
    @(negedge clk);
    cand_x = vecs[5].cx; cand_y = vecs[5].cy; cand_spin = 2'd2; rot_req = 1'b1;
    load = 1'b1; load_x = {4'd1, 4'd1, 4'd1, 4'd1}; load_y = {4'd3, 4'd2, 4'd1, 4'd0};
    @(negedge clk);
    load = 1'b0; rot_req = 1'b0;
    check("load+req busy", 64'(busy), 64'd0);
    check("load+req cur_x", 64'(cur_x), 64'h1111);
    count_done(6, n);
    check("load+req no done", 64'(n), 64'd0);

    // Commit to get a nonzero spin, then abort a check with load
    attempt(0);
    @(negedge clk);
    cand_x = vecs[5].cx; cand_y = vecs[5].cy; cand_spin = 2'd2; rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    check("abort in check", 64'(busy), 64'd1);
    @(negedge clk);
    load = 1'b1; load_x = {4'd6, 4'd6, 4'd6, 4'd6}; load_y = {4'd0, 4'd1, 4'd2, 4'd3};
    @(negedge clk);
    load = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort cur_x", 64'(cur_x), 64'h6666);
    check("abort cur_y", 64'(cur_y), 64'h0123);
    check("abort spin", 64'(spin_state), 64'd0);
    count_done(6, n);
    check("abort no done", 64'(n), 64'd0);

    // Reset during CHECK
    @(negedge clk);
    cand_x = vecs[0].cx; cand_y = vecs[0].cy; cand_spin = 2'd3; rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst mid busy", 64'(busy), 64'd0);
    check("rst mid cur_x", 64'(cur_x), 64'd0);
    check("rst mid spin", 64'(spin_state), 64'd0);
    count_done(6, n);
    check("rst mid no done", 64'(n), 64'd0);
    check("rst mid ok", 64'(ok), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
